sdio_cmd_frame_gen: RTL

Parametrised SDIO CMD-line frame generator. Serialises 48-bit command/response frames (start bit, direction bit, 6-bit index, 32-bit argument, CRC7, end bit) onto the CMD line with programmable power-up idle and inter-frame gap. It adds automatic CRC7 generation, a ready/start handshake and a completed-frame counter. It drives the CMD line into the SDIO receive path as a reusable stimulus/host-side block in place of hard-coded frame sequencing.

---
 rtl/sdio_cmd_frame_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sdio_cmd_frame_gen.sv
// SDIO CMD-line frame generator: serialises {start, dir, index, arg, CRC7, end}
// MSB first on the falling edge of sd_clk, with power-up idle and inter-frame gap.
module sdio_cmd_frame_gen #(
  parameter int unsigned INIT_DELAY = 200,
  parameter int unsigned GAP_DELAY  = 200,
  parameter bit          CRC_EN     = 1'b1
) (
  input  logic        sd_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dir,
  input  logic [5:0]  index,
  input  logic [31:0] arg,
  input  logic [6:0]  crc_in,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        cmd_o,
  output logic        cmd_oe,
  output logic [15:0] frame_cnt
);

  localparam int unsigned MAXD = (INIT_DELAY > GAP_DELAY) ? INIT_DELAY : GAP_DELAY;
  localparam int unsigned DW   = (MAXD < 2) ? 1 : $clog2(MAXD);
  localparam logic [DW-1:0] INIT_LAST = DW'(INIT_DELAY - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_DELAY - 1);

  typedef enum logic [3:0] {
    INIT = 4'b0001,
    IDLE = 4'b0010,
    SEND = 4'b0100,
    GAP  = 4'b1000
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [5:0]    bit_q, bit_d;
  logic [47:0]   frame_q, frame_d;
  logic [6:0]    crc_q, crc_d;
  logic          cmd_q, cmd_d;
  logic          oe_q, oe_d;
  logic          done_q, done_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          crc_slot;
  logic          frame_bit;
  logic          crc_fb;

  // Bit positions 7:1 of the frame come from the CRC register when generating internally.
  assign crc_slot  = CRC_EN && (bit_q >= 6'd40) && (bit_q <= 6'd46);
  assign frame_bit = crc_slot ? crc_q[6] : frame_q[47];
  assign crc_fb    = frame_q[47] ^ crc_q[6];

  always_ff @(negedge sd_clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      dly_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      crc_q   <= '0;
      cmd_q   <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      crc_q   <= crc_d;
      cmd_q   <= cmd_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (dly_q == INIT_LAST) state_d = IDLE;
      IDLE:    if (start) state_d = SEND;
      SEND:    if (bit_q == 6'd48) state_d = GAP;
      GAP:     if (dly_q == GAP_LAST) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    dly_d   = dly_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    crc_d   = crc_q;
    cmd_d   = 1'b1;
    oe_d    = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: dly_d = (dly_q == INIT_LAST) ? '0 : dly_q + DW'(1);
      IDLE: begin
        if (start) begin
          frame_d = {1'b0, dir, index, arg, (CRC_EN ? 7'd0 : crc_in), 1'b1};
          crc_d   = '0;
          bit_d   = '0;
          dly_d   = '0;
        end
      end
      SEND: begin
        if (bit_q != 6'd48) begin
          cmd_d   = frame_bit;
          oe_d    = 1'b1;
          frame_d = {frame_q[46:0], 1'b0};
          bit_d   = bit_q + 6'd1;
          // CRC7 (x^7+x^3+1) over bits 47..8, then the register itself shifts out.
          if (bit_q < 6'd40) crc_d = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
          else               crc_d = {crc_q[5:0], 1'b0};
        end else begin
          done_d = 1'b1;
          cnt_d  = cnt_q + 16'd1;
          dly_d  = '0;
        end
      end
      GAP: dly_d = (dly_q == GAP_LAST) ? '0 : dly_q + DW'(1);
      default: dly_d = '0;
    endcase
  end

  always_comb begin
    ready     = (state_q == IDLE);
    busy      = (state_q == SEND) || (state_q == GAP);
    done      = done_q;
    cmd_o     = cmd_q;
    cmd_oe    = oe_q;
    frame_cnt = cnt_q;
  end

endmodule
